// File: rtl/id_exe_reg.sv
// ID->EXE two-entry skid pipeline register, optional operand forwarding when FWD_EN is defined.
// Latency: 1 cycle from accept to out_valid; strict FIFO order between main and skid entries.
// Backpressure: in_ready depends only on registered skid occupancy and rst, never on out_ready.
module id_exe_reg #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CMD_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_pc,
    input  logic [DATA_W-1:0] in_val1,
    input  logic [DATA_W-1:0] in_val2,
    input  logic [DATA_W-1:0] in_st_val,
    input  logic [CMD_W-1:0]  in_exe_cmd,
    input  logic              in_mem_r_en,
    input  logic              in_mem_w_en,
    input  logic              in_wb_en,
    input  logic [REG_AW-1:0] in_dest,
`ifdef FWD_EN
    input  logic [REG_AW-1:0] in_src1,
    input  logic [REG_AW-1:0] in_src2,
    input  logic              fwd_mem_wb_en,
    input  logic [REG_AW-1:0] fwd_mem_dest,
    input  logic [DATA_W-1:0] fwd_mem_val,
    input  logic              fwd_wb_wb_en,
    input  logic [REG_AW-1:0] fwd_wb_dest,
    input  logic [DATA_W-1:0] fwd_wb_val,
    output logic [REG_AW-1:0] out_src1,
    output logic [REG_AW-1:0] out_src2,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_pc,
    output logic [DATA_W-1:0] out_val1,
    output logic [DATA_W-1:0] out_val2,
    output logic [DATA_W-1:0] out_st_val,
    output logic [CMD_W-1:0]  out_exe_cmd,
    output logic              out_mem_r_en,
    output logic              out_mem_w_en,
    output logic              out_wb_en,
    output logic [REG_AW-1:0] out_dest
);

    typedef struct packed {
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] val1;
        logic [DATA_W-1:0] val2;
        logic [DATA_W-1:0] st_val;
        logic [CMD_W-1:0]  exe_cmd;
        logic              mem_r_en;
        logic              mem_w_en;
        logic              wb_en;
        logic [REG_AW-1:0] dest;
`ifdef FWD_EN
        logic [REG_AW-1:0] src1;
        logic [REG_AW-1:0] src2;
`endif
    } pl_t;

    pl_t  in_dat, m_dat_q, m_dat_d, s_dat_q, s_dat_d;
    logic m_vld_q, m_vld_d, s_vld_q, s_vld_d;
    logic accept, pop;

    always_comb begin
        in_dat          = '0;
        in_dat.pc       = in_pc;
        in_dat.val1     = in_val1;
        in_dat.val2     = in_val2;
        in_dat.st_val   = in_st_val;
        in_dat.exe_cmd  = in_exe_cmd;
        in_dat.mem_r_en = in_mem_r_en;
        in_dat.mem_w_en = in_mem_w_en;
        in_dat.wb_en    = in_wb_en;
        in_dat.dest     = in_dest;
`ifdef FWD_EN
        in_dat.src1     = in_src1;
        in_dat.src2     = in_src2;
`endif
    end

    assign in_ready = ~s_vld_q & ~rst;
    assign accept   = in_valid & in_ready;
    assign pop      = m_vld_q & out_ready;

    always_comb begin
        m_vld_d = m_vld_q;
        s_vld_d = s_vld_q;
        m_dat_d = m_dat_q;
        s_dat_d = s_dat_q;
        if (flush) begin
            m_vld_d = 1'b0;
            s_vld_d = 1'b0;
        end else if (s_vld_q) begin
            // Skid entry moves up before anything new is taken, preserving order.
            if (pop) begin
                m_dat_d = s_dat_q;
                s_vld_d = 1'b0;
            end
        end else if (!m_vld_q || pop) begin
            m_vld_d = accept;
            if (accept) m_dat_d = in_dat;
        end else if (accept) begin
            s_vld_d = 1'b1;
            s_dat_d = in_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_vld_q <= 1'b0;
            s_vld_q <= 1'b0;
            m_dat_q <= '0;
            s_dat_q <= '0;
        end else begin
            m_vld_q <= m_vld_d;
            s_vld_q <= s_vld_d;
            m_dat_q <= m_dat_d;
            s_dat_q <= s_dat_d;
        end
    end

    assign out_valid    = m_vld_q;
    assign out_pc       = m_dat_q.pc;
    assign out_exe_cmd  = m_dat_q.exe_cmd;
    assign out_mem_r_en = m_dat_q.mem_r_en & m_vld_q;
    assign out_mem_w_en = m_dat_q.mem_w_en & m_vld_q;
    assign out_wb_en    = m_dat_q.wb_en & m_vld_q;
    assign out_dest     = m_dat_q.dest;

`ifdef FWD_EN
    logic mem_hit1, wb_hit1, mem_hit2, wb_hit2;

    assign out_src1 = m_dat_q.src1;
    assign out_src2 = m_dat_q.src2;
    assign mem_hit1 = fwd_mem_wb_en & (fwd_mem_dest == m_dat_q.src1) & (m_dat_q.src1 != '0);
    assign wb_hit1  = fwd_wb_wb_en  & (fwd_wb_dest  == m_dat_q.src1) & (m_dat_q.src1 != '0);
    assign mem_hit2 = fwd_mem_wb_en & (fwd_mem_dest == m_dat_q.src2) & (m_dat_q.src2 != '0);
    assign wb_hit2  = fwd_wb_wb_en  & (fwd_wb_dest  == m_dat_q.src2) & (m_dat_q.src2 != '0);

    assign out_val1   = mem_hit1 ? fwd_mem_val : wb_hit1 ? fwd_wb_val : m_dat_q.val1;
    assign out_val2   = mem_hit2 ? fwd_mem_val : wb_hit2 ? fwd_wb_val : m_dat_q.val2;
    assign out_st_val = mem_hit2 ? fwd_mem_val : wb_hit2 ? fwd_wb_val : m_dat_q.st_val;
`else
    assign out_val1   = m_dat_q.val1;
    assign out_val2   = m_dat_q.val2;
    assign out_st_val = m_dat_q.st_val;
`endif

endmodule
